sys_array_cmd_scheduler: RTL and testbench

- Host-facing command front end that sits directly upstream of sys_array_controller.
- Two threads (0, 1) each push LOAD (B preload) or COMP (A×B+D→C) commands into a private in-order FIFO.
- Per-thread FSMs turn queue heads into comp/load lock requests with held base addresses, track grant and finish, and report completions back to the host.

---
 rtl/sys_array_cmd_scheduler.sv | 157 +++++++++++++++
 tb/tb_sys_array_cmd_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_array_cmd_scheduler.sv
// rtl/sys_array_cmd_scheduler.sv - two-thread command FIFO and lock-request scheduler (optional macro SCHED_PERF_CTR_EN)
module sys_array_cmd_scheduler #(
    parameter int BITWIDTH   = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          cmd_valid,
    output logic [1:0]          cmd_ready,
    input  logic [1:0]          cmd_is_comp,
    input  logic [BITWIDTH-1:0] cmd_a_addr [1:0],
    input  logic [BITWIDTH-1:0] cmd_d_addr [1:0],
    input  logic [BITWIDTH-1:0] cmd_c_addr [1:0],
    input  logic [BITWIDTH-1:0] cmd_b_addr [1:0],
    output logic [1:0]          comp_lock_req,
    output logic [BITWIDTH-1:0] A_addr [1:0],
    output logic [BITWIDTH-1:0] D_addr [1:0],
    output logic [BITWIDTH-1:0] C_addr [1:0],
    output logic [1:0]          load_lock_req,
    output logic [BITWIDTH-1:0] B_addr [1:0],
    input  logic [1:0]          comp_lock_res,
    input  logic [1:0]          load_lock_res,
    input  logic                comp_finished,
    input  logic                load_finished,
    output logic [1:0]          done_valid,
    output logic [1:0]          done_is_comp,
    output logic [CNT_W-1:0]    pending [1:0],
    output logic                proto_err
`ifdef SCHED_PERF_CTR_EN
    ,
    output logic [31:0]         wait_cycles [1:0],
    output logic [31:0]         run_cycles [1:0]
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RUN = 2'd2} state_t;

    typedef struct packed {
        logic                is_comp;
        logic [BITWIDTH-1:0] a_addr;
        logic [BITWIDTH-1:0] d_addr;
        logic [BITWIDTH-1:0] c_addr;
        logic [BITWIDTH-1:0] b_addr;
    } cmd_t;

    cmd_t             fifo_mem [2][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr [2];
    logic [PTR_W-1:0] rd_ptr [2];
    logic [CNT_W-1:0] count [2];
    state_t           state [2];
    cmd_t             active [2];
    cmd_t             cmd_in [2];
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       grant;
    logic [1:0]       finish;
    logic [1:0]       err;

    // Per-thread handshake, request/address drive and protocol-error decode from current state
    always_comb begin
        cmd_ready     = '0;
        push          = '0;
        pop           = '0;
        comp_lock_req = '0;
        load_lock_req = '0;
        grant         = '0;
        finish        = '0;
        err           = '0;
        for (int t = 0; t < 2; t++) begin
            cmd_in[t]        = {cmd_is_comp[t], cmd_a_addr[t], cmd_d_addr[t], cmd_c_addr[t], cmd_b_addr[t]};
            cmd_ready[t]     = !reset && (count[t] != CNT_W'(FIFO_DEPTH));
            push[t]          = cmd_valid[t] && cmd_ready[t];
            pop[t]           = (state[t] == IDLE) && (count[t] != '0);
            comp_lock_req[t] = (state[t] == REQ) && active[t].is_comp;
            load_lock_req[t] = (state[t] == REQ) && !active[t].is_comp;
            A_addr[t]        = comp_lock_req[t] ? active[t].a_addr : '0;
            D_addr[t]        = comp_lock_req[t] ? active[t].d_addr : '0;
            C_addr[t]        = comp_lock_req[t] ? active[t].c_addr : '0;
            B_addr[t]        = load_lock_req[t] ? active[t].b_addr : '0;
            grant[t]         = active[t].is_comp ? comp_lock_res[t] : load_lock_res[t];
            finish[t]        = active[t].is_comp ? comp_finished : load_finished;
            err[t]           = (comp_lock_res[t] && !((state[t] != IDLE) && active[t].is_comp))
                            || (load_lock_res[t] && !((state[t] != IDLE) && !active[t].is_comp))
                            || (comp_lock_res[t] && load_lock_res[t]);
            pending[t]       = count[t] + CNT_W'(state[t] != IDLE);
        end
    end

    // FIFO storage and pointers, per-thread IDLE/REQ/RUN sequencing, retire pulses, sticky error
    always_ff @(posedge clock) begin
        if (reset) begin
            proto_err    <= 1'b0;
            done_valid   <= '0;
            done_is_comp <= '0;
            for (int t = 0; t < 2; t++) begin
                wr_ptr[t] <= '0;
                rd_ptr[t] <= '0;
                count[t]  <= '0;
                state[t]  <= IDLE;
                active[t] <= '0;
            end
        end else begin
            if (|err) begin
                proto_err <= 1'b1;
            end
            for (int t = 0; t < 2; t++) begin
                done_valid[t]   <= 1'b0;
                done_is_comp[t] <= 1'b0;
                if (push[t]) begin
                    fifo_mem[t][wr_ptr[t]] <= cmd_in[t];
                    wr_ptr[t]              <= wr_ptr[t] + PTR_W'(1);
                end
                if (pop[t]) begin
                    active[t] <= fifo_mem[t][rd_ptr[t]];
                    rd_ptr[t] <= rd_ptr[t] + PTR_W'(1);
                end
                count[t] <= count[t] + CNT_W'(push[t]) - CNT_W'(pop[t]);
                case (state[t])
                    IDLE: if (pop[t]) state[t] <= REQ;
                    REQ:  if (grant[t]) state[t] <= RUN;
                    RUN: begin
                        if (grant[t] && finish[t]) begin
                            state[t]        <= IDLE;
                            done_valid[t]   <= 1'b1;
                            done_is_comp[t] <= active[t].is_comp;
                        end
                    end
                    default: state[t] <= IDLE;
                endcase
            end
        end
    end

`ifdef SCHED_PERF_CTR_EN
    // Saturating cycle counters for time spent waiting for a grant and holding the lock
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int t = 0; t < 2; t++) begin
                wait_cycles[t] <= '0;
                run_cycles[t]  <= '0;
            end
        end else begin
            for (int t = 0; t < 2; t++) begin
                if ((state[t] == REQ) && (wait_cycles[t] != '1)) begin
                    wait_cycles[t] <= wait_cycles[t] + 32'd1;
                end
                if ((state[t] == RUN) && (run_cycles[t] != '1)) begin
                    run_cycles[t] <= run_cycles[t] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sys_array_cmd_scheduler.sv
// tb/tb_sys_array_cmd_scheduler.sv - self-checking bench for sys_array_cmd_scheduler
module tb_sys_array_cmd_scheduler;
    localparam int BW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [1:0]    cmd_valid = '0, cmd_ready, cmd_is_comp = '0;
    logic [BW-1:0] cmd_a_addr [1:0], cmd_d_addr [1:0], cmd_c_addr [1:0], cmd_b_addr [1:0];
    logic [1:0]    comp_lock_req, load_lock_req;
    logic [BW-1:0] A_addr [1:0], D_addr [1:0], C_addr [1:0], B_addr [1:0];
    logic [1:0]    comp_lock_res = '0, load_lock_res = '0;
    logic          comp_finished = 1'b0, load_finished = 1'b0;
    logic [1:0]    done_valid, done_is_comp;
    logic [CW-1:0] pending [1:0];
    logic          proto_err;
`ifdef SCHED_PERF_CTR_EN
    logic [31:0]   wait_cycles [1:0], run_cycles [1:0];
`endif

    sys_array_cmd_scheduler #(.BITWIDTH(BW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_comp(cmd_is_comp),
        .cmd_a_addr(cmd_a_addr), .cmd_d_addr(cmd_d_addr), .cmd_c_addr(cmd_c_addr), .cmd_b_addr(cmd_b_addr),
        .comp_lock_req(comp_lock_req), .A_addr(A_addr), .D_addr(D_addr), .C_addr(C_addr),
        .load_lock_req(load_lock_req), .B_addr(B_addr),
        .comp_lock_res(comp_lock_res), .load_lock_res(load_lock_res),
        .comp_finished(comp_finished), .load_finished(load_finished),
        .done_valid(done_valid), .done_is_comp(done_is_comp),
        .pending(pending), .proto_err(proto_err)
`ifdef SCHED_PERF_CTR_EN
        , .wait_cycles(wait_cycles), .run_cycles(run_cycles)
`endif
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    task automatic chk(input string name, input int t, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0h required=%0h at %0t", name, t, act, exp, $time);
        end
    endtask

    // Behavioural reference: a queue of waiting commands plus the one command being served
    typedef struct packed {
        logic          is_comp;
        logic [BW-1:0] a, d, c, b;
    } cmd_t;

    cmd_t    mq [2][$];
    cmd_t    m_act [2];
    bit      m_busy [2], m_granted [2], m_done [2], m_done_comp [2];
    bit      m_err;
    longint  m_wait [2], m_run [2];

    task automatic model_step();
        bit res, fin, retire, grnt, pop, push;
        cmd_t nc;
        if (reset) begin
            for (int t = 0; t < 2; t++) begin
                mq[t].delete();
                m_busy[t] = 0; m_granted[t] = 0; m_done[t] = 0; m_done_comp[t] = 0;
                m_act[t] = '0; m_wait[t] = 0; m_run[t] = 0;
            end
            m_err = 0;
            return;
        end
        for (int t = 0; t < 2; t++) begin
            if (comp_lock_res[t] && !(m_busy[t] && m_act[t].is_comp)) m_err = 1;
            if (load_lock_res[t] && !(m_busy[t] && !m_act[t].is_comp)) m_err = 1;
            if (comp_lock_res[t] && load_lock_res[t]) m_err = 1;
            if (m_busy[t] && !m_granted[t]) m_wait[t]++;
            if (m_busy[t] && m_granted[t]) m_run[t]++;
            res    = m_act[t].is_comp ? comp_lock_res[t] : load_lock_res[t];
            fin    = m_act[t].is_comp ? comp_finished : load_finished;
            retire = m_busy[t] && m_granted[t] && res && fin;
            grnt   = m_busy[t] && !m_granted[t] && res;
            pop    = !m_busy[t] && (mq[t].size() > 0);
            push   = cmd_valid[t] && (mq[t].size() < DEPTH);
            m_done[t]      = retire;
            m_done_comp[t] = retire && m_act[t].is_comp;
            if (retire) m_busy[t] = 0;
            if (grnt) m_granted[t] = 1;
            if (pop) begin
                m_act[t] = mq[t].pop_front();
                m_busy[t] = 1;
                m_granted[t] = 0;
            end
            if (push) begin
                nc = {cmd_is_comp[t], cmd_a_addr[t], cmd_d_addr[t], cmd_c_addr[t], cmd_b_addr[t]};
                mq[t].push_back(nc);
            end
        end
    endtask

    always @(posedge clock) model_step();

    // Every-cycle comparison of all DUT outputs against the reference
    always @(negedge clock) begin
        if (chk_en) begin
            for (int t = 0; t < 2; t++) begin
                bit creq, lreq;
                creq = m_busy[t] && !m_granted[t] && m_act[t].is_comp;
                lreq = m_busy[t] && !m_granted[t] && !m_act[t].is_comp;
                chk("cmd_ready", t, 64'(cmd_ready[t]), 64'(!reset && (mq[t].size() < DEPTH)));
                chk("comp_lock_req", t, 64'(comp_lock_req[t]), 64'(creq));
                chk("load_lock_req", t, 64'(load_lock_req[t]), 64'(lreq));
                chk("A_addr", t, 64'(A_addr[t]), creq ? 64'(m_act[t].a) : 64'(0));
                chk("D_addr", t, 64'(D_addr[t]), creq ? 64'(m_act[t].d) : 64'(0));
                chk("C_addr", t, 64'(C_addr[t]), creq ? 64'(m_act[t].c) : 64'(0));
                chk("B_addr", t, 64'(B_addr[t]), lreq ? 64'(m_act[t].b) : 64'(0));
                chk("pending", t, 64'(pending[t]), 64'(mq[t].size() + int'(m_busy[t])));
                chk("done_valid", t, 64'(done_valid[t]), 64'(m_done[t]));
                if (m_done[t]) chk("done_is_comp", t, 64'(done_is_comp[t]), 64'(m_done_comp[t]));
`ifdef SCHED_PERF_CTR_EN
                chk("wait_cycles", t, 64'(wait_cycles[t]), 64'(m_wait[t]));
                chk("run_cycles", t, 64'(run_cycles[t]), 64'(m_run[t]));
`endif
            end
            chk("proto_err", 0, 64'(proto_err), 64'(m_err));
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    int comp_owner, load_owner;

    initial begin
        for (int t = 0; t < 2; t++) begin
            cmd_a_addr[t] = '0; cmd_d_addr[t] = '0; cmd_c_addr[t] = '0; cmd_b_addr[t] = '0;
        end
        tick();
        chk_en = 1;
        tick();
        chk("rst_pending0", 0, 64'(pending[0]), 64'(0));
        chk("rst_cmd_ready", 0, 64'(cmd_ready), 64'(0));
        chk("rst_reqs", 0, 64'({comp_lock_req, load_lock_req}), 64'(0));
        chk("rst_proto_err", 0, 64'(proto_err), 64'(0));
        reset = 0;
        tick();
        chk("post_rst_ready", 0, 64'(cmd_ready), 64'(2'b11));

        // Thread 0 COMP: request two edges after push, grant after 3 request cycles, 10 run cycles
        cmd_valid[0] = 1; cmd_is_comp[0] = 1;
        cmd_a_addr[0] = 16'h10; cmd_d_addr[0] = 16'h20; cmd_c_addr[0] = 16'h30; cmd_b_addr[0] = 16'h99;
        tick();
        cmd_valid[0] = 0;
        chk("t1_req_early", 0, 64'(comp_lock_req[0]), 64'(0));
        chk("t1_pending_q", 0, 64'(pending[0]), 64'(1));
        tick();
        chk("t1_req", 0, 64'(comp_lock_req[0]), 64'(1));
        chk("t1_A", 0, 64'(A_addr[0]), 64'h10);
        chk("t1_C", 0, 64'(C_addr[0]), 64'h30);
        tick();
        tick();
        comp_lock_res[0] = 1;
        tick();
        chk("t1_req_drop", 0, 64'(comp_lock_req[0]), 64'(0));
        chk("t1_A_zero", 0, 64'(A_addr[0]), 64'(0));
        for (int i = 0; i < 9; i++) tick();
        comp_finished = 1;
        tick();
        comp_finished = 0; comp_lock_res[0] = 0;
        chk("t1_done", 0, 64'(done_valid[0]), 64'(1));
        chk("t1_done_comp", 0, 64'(done_is_comp[0]), 64'(1));
        chk("t1_pending_end", 0, 64'(pending[0]), 64'(0));
`ifdef SCHED_PERF_CTR_EN
        chk("t1_wait", 0, 64'(wait_cycles[0]), 64'(3));
        chk("t1_run", 0, 64'(run_cycles[0]), 64'(10));
`endif
        tick();
        chk("t1_done_pulse", 0, 64'(done_valid[0]), 64'(0));

        // Thread 1 fill: 5 accepted (one in REQ + 4 queued), 6th refused
        for (int i = 0; i < 6; i++) begin
            cmd_valid[1] = 1;
            cmd_is_comp[1] = (i == 0) ? 1'b1 : 1'(i % 2);
            cmd_a_addr[1] = 16'h100 + 16'(i); cmd_d_addr[1] = 16'h200 + 16'(i);
            cmd_c_addr[1] = 16'h300 + 16'(i); cmd_b_addr[1] = 16'h400 + 16'(i);
            tick();
        end
        cmd_valid[1] = 0;
        chk("t2_pending", 1, 64'(pending[1]), 64'(5));
        chk("t2_ready", 1, 64'(cmd_ready[1]), 64'(0));
        chk("t2_A", 1, 64'(A_addr[1]), 64'h100);

        // Thread 0 LOAD concurrent with thread 1 COMP, both granted on one edge
        cmd_valid[0] = 1; cmd_is_comp[0] = 0; cmd_b_addr[0] = 16'h40;
        tick();
        cmd_valid[0] = 0;
        tick();
        chk("t3_lreq", 0, 64'(load_lock_req[0]), 64'(1));
        chk("t3_B", 0, 64'(B_addr[0]), 64'h40);
        load_lock_res[0] = 1; comp_lock_res[1] = 1;
        tick();
        chk("t3_reqs_drop", 0, 64'({comp_lock_req, load_lock_req}), 64'(0));
        tick();
        load_finished = 1;
        tick();
        load_finished = 0; load_lock_res[0] = 0;
        chk("t3_done0", 0, 64'(done_valid), 64'(2'b01));
        chk("t3_done0_type", 0, 64'(done_is_comp[0]), 64'(0));
        tick();
        comp_finished = 1;
        tick();
        comp_finished = 0; comp_lock_res[1] = 0;
        chk("t3_done1", 1, 64'(done_valid), 64'(2'b10));
        chk("t3_done1_type", 1, 64'(done_is_comp[1]), 64'(1));
        chk("t3_no_err", 0, 64'(proto_err), 64'(0));

        // Reset while thread 1 runs with 3 queued
        tick();
        chk("t5_pending_pre", 1, 64'(pending[1]), 64'(4));
        comp_lock_res[1] = 1;
        tick();
        reset = 1; comp_lock_res[1] = 0;
        tick();
        chk("t5_reqs", 0, 64'({comp_lock_req, load_lock_req}), 64'(0));
        chk("t5_pending1", 1, 64'(pending[1]), 64'(0));
        chk("t5_done", 0, 64'(done_valid), 64'(0));
        reset = 0;
        tick();
        chk("t5_ready", 0, 64'(cmd_ready), 64'(2'b11));

        // Spurious load grant to idle thread 0 -> sticky error until reset
        load_lock_res[0] = 1;
        tick();
        load_lock_res[0] = 0;
        chk("t4_err", 0, 64'(proto_err), 64'(1));
        tick();
        tick();
        chk("t4_err_sticky", 0, 64'(proto_err), 64'(1));
        reset = 1;
        tick();
        reset = 0;
        chk("t4_err_clr", 0, 64'(proto_err), 64'(0));
        tick();

        // Randomized traffic against a legal controller (one owner per lock type)
        comp_owner = -1; load_owner = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int t = 0; t < 2; t++) begin
                cmd_valid[t]   = ($urandom_range(0, 9) < 4);
                cmd_is_comp[t] = 1'($urandom_range(0, 1));
                cmd_a_addr[t] = BW'($urandom); cmd_d_addr[t] = BW'($urandom);
                cmd_c_addr[t] = BW'($urandom); cmd_b_addr[t] = BW'($urandom);
            end
            if (comp_owner >= 0 && !m_busy[comp_owner]) comp_owner = -1;
            if (load_owner >= 0 && !m_busy[load_owner]) load_owner = -1;
            for (int t = 0; t < 2; t++) begin
                if (m_busy[t] && !m_granted[t] && $urandom_range(0, 2) == 0) begin
                    if (m_act[t].is_comp && comp_owner < 0) comp_owner = t;
                    if (!m_act[t].is_comp && load_owner < 0) load_owner = t;
                end
            end
            comp_lock_res = (comp_owner >= 0) ? 2'(1 << comp_owner) : 2'b00;
            load_lock_res = (load_owner >= 0) ? 2'(1 << load_owner) : 2'b00;
            comp_finished = (comp_owner >= 0) ? (m_granted[comp_owner] && $urandom_range(0, 3) == 0)
                                              : ($urandom_range(0, 7) == 0);
            load_finished = (load_owner >= 0) ? (m_granted[load_owner] && $urandom_range(0, 3) == 0)
                                              : ($urandom_range(0, 7) == 0);
            tick();
        end
        cmd_valid = '0; comp_lock_res = '0; load_lock_res = '0;
        comp_finished = 0; load_finished = 0;
        tick();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
